// File: rtl/quant_arbiter.sv
// Round-robin scheduler sharing one quantizer between Y/Cb/Cr block streams.
// Optional WAIT watchdog enabled by defining QUANT_ARB_TIMEOUT_EN.
module quant_arbiter #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    output logic [2:0]       grant,
    output logic [1:0]       sel,
    output logic             table_sel,
    output logic             q_enable,
    input  logic             q_out_enable,
    output logic [2:0]       ack,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count,
    output logic             error
);

    // state   | meaning
    // S_IDLE  | no transaction; arbitrate on req
    // S_SETUP | grant/sel held while the Z mux settles
    // S_FIRE  | q_enable pulse to the quantizer
    // S_WAIT  | waiting for q_out_enable
    // S_ACK   | ack pulse, count block, move RR pointer
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FIRE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [2:0] setup_cnt;
    logic [1:0] pick_idx;
    logic       pick_vld;
    logic [1:0] c0, c1, c2;

`ifdef QUANT_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WD_W-1:0] wd_cnt;
`endif

    // Search order starts one past the last granted index.
    always_comb begin
        c0 = 2'd0;
        c1 = 2'd1;
        c2 = 2'd2;
        case (ptr)
            2'd0: begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1: begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        pick_vld = 1'b1;
        pick_idx = c0;
        if (req[c0])      pick_idx = c0;
        else if (req[c1]) pick_idx = c1;
        else if (req[c2]) pick_idx = c2;
        else              pick_vld = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= 2'd2;
            grant     <= 3'b000;
            sel       <= 2'd3;
            table_sel <= 1'b0;
            q_enable  <= 1'b0;
            ack       <= 3'b000;
            busy      <= 1'b0;
            blk_count <= '0;
            setup_cnt <= 3'd0;
`ifdef QUANT_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
            error     <= 1'b0;
`endif
        end else begin
            q_enable <= 1'b0;
            ack      <= 3'b000;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant     <= 3'b001 << pick_idx;
                        sel       <= pick_idx;
                        table_sel <= (pick_idx != 2'd0);
                        setup_cnt <= 3'(SETUP_CYC);
                        busy      <= 1'b1;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (setup_cnt <= 3'd1) begin
                        setup_cnt <= 3'd0;
                        q_enable  <= 1'b1;
                        state     <= S_FIRE;
                    end else begin
                        setup_cnt <= setup_cnt - 3'd1;
                    end
                end
                S_FIRE: begin
`ifdef QUANT_ARB_TIMEOUT_EN
                    wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (q_out_enable) begin
                        ack       <= grant;
                        blk_count <= blk_count + CNT_W'(1);
                        ptr       <= sel;
                        state     <= S_ACK;
                    end
`ifdef QUANT_ARB_TIMEOUT_EN
                    // Stalled quantizer: drop the block and skip past its requester.
                    else if (wd_cnt == '0) begin
                        error     <= 1'b1;
                        ptr       <= sel;
                        grant     <= 3'b000;
                        sel       <= 2'd3;
                        table_sel <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
`endif
                end
                S_ACK: begin
                    grant     <= 3'b000;
                    sel       <= 2'd3;
                    table_sel <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef QUANT_ARB_TIMEOUT_EN
    assign error = 1'b0;
`endif

endmodule

// File: doc/quant_arbiter.md
Name: quant_arbiter

Overview:
- Control-plane scheduler that time-shares one 8x8 quantizer engine between the Y, Cb and Cr block streams.
- Arbitrates round-robin between the three component requesters and selects the quantization table (luma or chroma).
- Drives the external Z-input mux select and pulses the quantizer enable, then waits for the quantizer out_enable and acks the granted requester.
- Sits between the DCT output buffers and the shared quantizer; it carries no coefficient data itself.

Parameters:
- SETUP_CYC, default 1: cycles from grant to q_enable, for Z mux settling; legal range 1..7.
- TIMEOUT_CYC, default 64: WAIT-state watchdog limit in cycles; used only with the optional feature.
- CNT_W, default 16: width of the completed-block counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  3  block-ready request; bit0 = Y, bit1 = Cb, bit2 = Cr; level, held by the requester until ack.
- grant  out  3  one-hot grant; held for the whole transaction; 0 when idle.
- sel  out  2  Z mux select; 0 = Y, 1 = Cb, 2 = Cr, 3 = none.
- table_sel  out  1  0 = luma table, 1 = chroma table; valid whenever grant != 0.
- q_enable  out  1  one-cycle start pulse to the quantizer enable.
- q_out_enable  in  1  quantizer result-valid pulse.
- ack  out  3  one-cycle pulse on the granted bit when its result is valid.
- busy  out  1  high in every state except IDLE.
- blk_count  out  CNT_W  completed blocks; wraps to 0 after all-ones.
- error  out  1  sticky watchdog flag; tied 0 when the optional feature is out.

Behaviour:
- Reset (rst = 0, asynchronous) forces:
  - grant = 0, sel = 3, table_sel = 0, q_enable = 0, ack = 0, busy = 0, blk_count = 0, error = 0.
  - FSM to IDLE; RR pointer = Cr, so Y has first priority after reset.
- All outputs are registered.
- FSM states: IDLE, SETUP, FIRE, WAIT, ACK.
- IDLE:
  - If req != 0, pick the first set bit searching from pointer+1 mod 3. Register grant, sel and table_sel (table_sel = 1 for Cb/Cr). Load setup counter = SETUP_CYC. Go to SETUP.
  - If req == 0, stay in IDLE.
- SETUP:
  - Decrement counter; when it reaches 0, go to FIRE.
  - grant, sel and table_sel are stable throughout.
- FIRE: q_enable = 1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Hold until q_out_enable = 1, then go to ACK.
  - q_out_enable is sampled only in WAIT; pulses in any other state are ignored.
- ACK:
  - ack = grant for one cycle; blk_count increments; RR pointer = granted index.
  - Next state is IDLE, where grant = 0 and sel = 3.
- Timing: with req seen in IDLE at edge n, grant is visible after edge n, and q_enable is high in cycle n+1+SETUP_CYC.
- Minimum back-to-back spacing: one IDLE cycle between ACK and the next grant.
- Fairness: a continuously asserted requester cannot starve the others; with all three asserted, the grant order cycles Y, Cb, Cr.
- Requester drops req mid-transaction: the transaction still completes and ack still pulses. The arbiter never aborts on req deassertion.
- req asserted during ACK: not considered until IDLE; the pointer is already updated.
- blk_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation: immediate return to reset values. A late q_out_enable from the in-flight block arrives in IDLE and is ignored; no ack, no count.

Optional Feature:
- Macro: QUANT_ARB_TIMEOUT_EN.
- With the macro defined:
  - A WAIT cycle counter is cleared on entry to WAIT.
  - If the counter reaches TIMEOUT_CYC with no q_out_enable, set error = 1 (sticky until reset) and go straight to IDLE.
  - On timeout: no ack, blk_count unchanged, RR pointer advances past the stalled requester.
- Without the macro: WAIT waits indefinitely, error is constant 0, and no watchdog counter is synthesized.

Test Plan:
- Single request: req = 001, quantizer latency 3 → grant 001, sel 0, table_sel 0; one q_enable pulse; ack 001 exactly once; blk_count = 1.
- Contention: req = 111 held continuously, each requester drops its bit on its own ack → grant order Y, Cb, Cr; table_sel 0, 1, 1; blk_count = 3; exactly one q_enable per grant.
- Fairness: Cr held permanently, Y re-asserted after each ack → grants alternate Y, Cr, Y, Cr over 6 transactions; Cb never granted.
- Spurious and late events:
  - q_out_enable pulsed while IDLE → no ack, blk_count unchanged.
  - req deasserted during WAIT → ack still pulses.
- Reset mid-WAIT: rst low for 2 cycles, then q_out_enable arrives → all outputs at reset values; no ack; blk_count = 0; next req = 100 is granted correctly.
- Watchdog and wrap:
  - With QUANT_ARB_TIMEOUT_EN and TIMEOUT_CYC = 8, never drive q_out_enable → error = 1 after 8 WAIT cycles, return to IDLE, no ack.
  - With CNT_W = 4, run 17 blocks → blk_count = 1.
